// File: rtl/rob_commit_pkg.sv
// rtl/rob_commit_pkg.sv - shared widths and commit-slot bundle for the ROB retirement controller
package rob_commit_pkg;

    localparam int PC_RANGE      = 32;
    localparam int LREG_RANGE    = 5;
    localparam int PREG_RANGE    = 7;
    localparam int ROB_DEPTH_DEF = 64;

    typedef struct packed {
        logic [PC_RANGE-1:0]   pc;
        logic [LREG_RANGE-1:0] lrd;
        logic [PREG_RANGE-1:0] prd;
        logic [PREG_RANGE-1:0] old_prd;
        logic                  need_to_wb;
        logic                  skip;
    } commit_slot_t;

endpackage

// File: rtl/rob_commit_slot.sv
// rtl/rob_commit_slot.sv - registered capture of one retire slot (valid plus entry fields)
module rob_commit_slot
    import rob_commit_pkg::*;
(
    input  logic         clock,
    input  logic         reset_n,
    input  logic         fire,
    input  commit_slot_t entry,
    output logic         vld,
    output commit_slot_t data
);

    logic         vld_d, vld_q;
    commit_slot_t data_d, data_q;

    // A slot that does not fire drops its valid but keeps its last data.
    always_comb begin
        vld_d  = fire;
        data_d = data_q;
        if (fire) begin
            data_d = entry;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

    assign vld  = vld_q;
    assign data = data_q;

endmodule

// File: rtl/rob_commit.sv
// rtl/rob_commit.sv - in-order two-wide ROB retirement with retired counter and head stall watchdog
module rob_commit
    import rob_commit_pkg::*;
#(
    parameter int ROB_DEPTH = ROB_DEPTH_DEF,
    parameter int IDX_W     = $clog2(ROB_DEPTH),
    parameter int TIMEOUT   = 4096
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic [ROB_DEPTH-1:0]            entry_ready_to_commit,
    input  logic [ROB_DEPTH-1:0]            entry_valid,
    input  logic [ROB_DEPTH*PC_RANGE-1:0]   entry_pc,
    input  logic [ROB_DEPTH*LREG_RANGE-1:0] entry_lrd,
    input  logic [ROB_DEPTH*PREG_RANGE-1:0] entry_prd,
    input  logic [ROB_DEPTH*PREG_RANGE-1:0] entry_old_prd,
    input  logic [ROB_DEPTH-1:0]            entry_need_to_wb,
    input  logic [ROB_DEPTH-1:0]            entry_skip,
    input  logic                            flush_vld,
    output logic [ROB_DEPTH-1:0]            commit_vld,
    output logic [IDX_W:0]                  head_ptr,
    output logic                            commit0_vld,
    output logic [PC_RANGE-1:0]             commit0_pc,
    output logic [LREG_RANGE-1:0]           commit0_lrd,
    output logic [PREG_RANGE-1:0]           commit0_prd,
    output logic [PREG_RANGE-1:0]           commit0_old_prd,
    output logic                            commit0_need_to_wb,
    output logic                            commit0_skip,
    output logic                            commit1_vld,
    output logic [PC_RANGE-1:0]             commit1_pc,
    output logic [LREG_RANGE-1:0]           commit1_lrd,
    output logic [PREG_RANGE-1:0]           commit1_prd,
    output logic [PREG_RANGE-1:0]           commit1_old_prd,
    output logic                            commit1_need_to_wb,
    output logic                            commit1_skip,
    output logic [63:0]                     retired_cnt,
    output logic                            stall_timeout
);

    localparam int STALL_W = $clog2(TIMEOUT) + 1;

    logic [IDX_W:0]   head_d, head_q;
    logic [63:0]      retired_cnt_d, retired_cnt_q;
    logic [STALL_W-1:0] stall_cnt_d, stall_cnt_q;
    logic             stall_timeout_d, stall_timeout_q;

    logic [IDX_W-1:0] h, h1;
    logic             slot0, slot1;
    commit_slot_t     entry0, entry1, data0, data1;

    assign h  = head_q[IDX_W-1:0];
    assign h1 = h + IDX_W'(1);

    // reset_n gating keeps the combinational pulse quiet while held in reset.
    assign slot0 = reset_n & ~flush_vld & entry_ready_to_commit[h];
    assign slot1 = slot0 & entry_ready_to_commit[h1];

    always_comb begin
        commit_vld = '0;
        if (slot0) commit_vld[h]  = 1'b1;
        if (slot1) commit_vld[h1] = 1'b1;
    end

    always_comb begin
        entry0.pc         = entry_pc[h*PC_RANGE +: PC_RANGE];
        entry0.lrd        = entry_lrd[h*LREG_RANGE +: LREG_RANGE];
        entry0.prd        = entry_prd[h*PREG_RANGE +: PREG_RANGE];
        entry0.old_prd    = entry_old_prd[h*PREG_RANGE +: PREG_RANGE];
        entry0.need_to_wb = entry_need_to_wb[h];
        entry0.skip       = entry_skip[h];
        entry1.pc         = entry_pc[h1*PC_RANGE +: PC_RANGE];
        entry1.lrd        = entry_lrd[h1*LREG_RANGE +: LREG_RANGE];
        entry1.prd        = entry_prd[h1*PREG_RANGE +: PREG_RANGE];
        entry1.old_prd    = entry_old_prd[h1*PREG_RANGE +: PREG_RANGE];
        entry1.need_to_wb = entry_need_to_wb[h1];
        entry1.skip       = entry_skip[h1];
    end

    always_comb begin
        head_d          = head_q + (IDX_W+1)'(slot0) + (IDX_W+1)'(slot1);
        retired_cnt_d   = retired_cnt_q + 64'(slot0) + 64'(slot1);
        stall_cnt_d     = stall_cnt_q;
        stall_timeout_d = stall_timeout_q;
        if (flush_vld) begin
            head_d = '0;
        end
        // The counter parks at TIMEOUT-1; the increment out of it raises the sticky flag.
        if (flush_vld || slot0 || !entry_valid[h]) begin
            stall_cnt_d = '0;
        end else if (stall_cnt_q == STALL_W'(TIMEOUT - 1)) begin
            stall_timeout_d = 1'b1;
        end else begin
            stall_cnt_d = stall_cnt_q + STALL_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_q          <= '0;
            retired_cnt_q   <= '0;
            stall_cnt_q     <= '0;
            stall_timeout_q <= 1'b0;
        end else begin
            head_q          <= head_d;
            retired_cnt_q   <= retired_cnt_d;
            stall_cnt_q     <= stall_cnt_d;
            stall_timeout_q <= stall_timeout_d;
        end
    end

    rob_commit_slot u_slot0 (
        .clock   (clock),
        .reset_n (reset_n),
        .fire    (slot0),
        .entry   (entry0),
        .vld     (commit0_vld),
        .data    (data0)
    );

    rob_commit_slot u_slot1 (
        .clock   (clock),
        .reset_n (reset_n),
        .fire    (slot1),
        .entry   (entry1),
        .vld     (commit1_vld),
        .data    (data1)
    );

    assign head_ptr           = head_q;
    assign retired_cnt        = retired_cnt_q;
    assign stall_timeout      = stall_timeout_q;

    assign commit0_pc         = data0.pc;
    assign commit0_lrd        = data0.lrd;
    assign commit0_prd        = data0.prd;
    assign commit0_old_prd    = data0.old_prd;
    assign commit0_need_to_wb = data0.need_to_wb;
    assign commit0_skip       = data0.skip;
    assign commit1_pc         = data1.pc;
    assign commit1_lrd        = data1.lrd;
    assign commit1_prd        = data1.prd;
    assign commit1_old_prd    = data1.old_prd;
    assign commit1_need_to_wb = data1.need_to_wb;
    assign commit1_skip       = data1.skip;

endmodule

// File: tb/tb_rob_commit.sv
// tb/tb_rob_commit.sv - directed self-checking bench for rob_commit
module tb_rob_commit;
    import rob_commit_pkg::*;

    localparam int DEPTH = 64;
    localparam int IW    = 6;

    logic                        clock;
    logic                        reset_n;
    logic [DEPTH-1:0]            entry_ready_to_commit;
    logic [DEPTH-1:0]            entry_valid;
    logic [DEPTH*PC_RANGE-1:0]   entry_pc;
    logic [DEPTH*LREG_RANGE-1:0] entry_lrd;
    logic [DEPTH*PREG_RANGE-1:0] entry_prd;
    logic [DEPTH*PREG_RANGE-1:0] entry_old_prd;
    logic [DEPTH-1:0]            entry_need_to_wb;
    logic [DEPTH-1:0]            entry_skip;
    logic                        flush_vld;
    logic [DEPTH-1:0]            commit_vld;
    logic [IW:0]                 head_ptr;
    logic                        commit0_vld, commit1_vld;
    logic [PC_RANGE-1:0]         commit0_pc, commit1_pc;
    logic [LREG_RANGE-1:0]       commit0_lrd, commit1_lrd;
    logic [PREG_RANGE-1:0]       commit0_prd, commit1_prd;
    logic [PREG_RANGE-1:0]       commit0_old_prd, commit1_old_prd;
    logic                        commit0_need_to_wb, commit1_need_to_wb;
    logic                        commit0_skip, commit1_skip;
    logic [63:0]                 retired_cnt;
    logic                        stall_timeout;

    int total = 0;
    int bad   = 0;

    rob_commit #(.ROB_DEPTH(DEPTH), .TIMEOUT(8)) dut (
        .clock                 (clock),
        .reset_n               (reset_n),
        .entry_ready_to_commit (entry_ready_to_commit),
        .entry_valid           (entry_valid),
        .entry_pc              (entry_pc),
        .entry_lrd             (entry_lrd),
        .entry_prd             (entry_prd),
        .entry_old_prd         (entry_old_prd),
        .entry_need_to_wb      (entry_need_to_wb),
        .entry_skip            (entry_skip),
        .flush_vld             (flush_vld),
        .commit_vld            (commit_vld),
        .head_ptr              (head_ptr),
        .commit0_vld           (commit0_vld),
        .commit0_pc            (commit0_pc),
        .commit0_lrd           (commit0_lrd),
        .commit0_prd           (commit0_prd),
        .commit0_old_prd       (commit0_old_prd),
        .commit0_need_to_wb    (commit0_need_to_wb),
        .commit0_skip          (commit0_skip),
        .commit1_vld           (commit1_vld),
        .commit1_pc            (commit1_pc),
        .commit1_lrd           (commit1_lrd),
        .commit1_prd           (commit1_prd),
        .commit1_old_prd       (commit1_old_prd),
        .commit1_need_to_wb    (commit1_need_to_wb),
        .commit1_skip          (commit1_skip),
        .retired_cnt           (retired_cnt),
        .stall_timeout         (stall_timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_entry(input int idx, input logic [PC_RANGE-1:0] pc, input logic [PREG_RANGE-1:0] old_prd,
                             input logic wb, input logic skip, input logic rdy);
        entry_valid[idx]                          = 1'b1;
        entry_ready_to_commit[idx]                = rdy;
        entry_pc[idx*PC_RANGE +: PC_RANGE]        = pc;
        entry_lrd[idx*LREG_RANGE +: LREG_RANGE]   = LREG_RANGE'(idx);
        entry_prd[idx*PREG_RANGE +: PREG_RANGE]   = PREG_RANGE'(idx + 1);
        entry_old_prd[idx*PREG_RANGE +: PREG_RANGE] = old_prd;
        entry_need_to_wb[idx]                     = wb;
        entry_skip[idx]                           = skip;
    endtask

    task automatic clr_entry(input int idx);
        entry_valid[idx]           = 1'b0;
        entry_ready_to_commit[idx] = 1'b0;
    endtask

    initial begin
        reset_n               = 1'b0;
        entry_ready_to_commit = '0;
        entry_valid           = '0;
        entry_pc              = '0;
        entry_lrd             = '0;
        entry_prd             = '0;
        entry_old_prd         = '0;
        entry_need_to_wb      = '0;
        entry_skip            = '0;
        flush_vld             = 1'b0;

        // reset state; a ready head must not pulse commit_vld while in reset
        set_entry(0, 32'h8000_0000, 7'd37, 1'b1, 1'b0, 1'b1);
        set_entry(1, 32'h8000_0004, 7'd3, 1'b0, 1'b1, 1'b1);
        tick();
        tick();
        chk("rst_commit_vld", commit_vld, 64'h0);
        chk("rst_head", head_ptr, 64'h0);
        chk("rst_c0_vld", commit0_vld, 64'h0);
        chk("rst_c0_pc", commit0_pc, 64'h0);
        chk("rst_retired", retired_cnt, 64'h0);
        chk("rst_timeout", stall_timeout, 64'h0);

        // entries 0 and 1 retire together
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        chk("dual_commit_vld", commit_vld, 64'h3);
        tick();
        clr_entry(0);
        clr_entry(1);
        #1;
        chk("dual_c0_vld", commit0_vld, 64'h1);
        chk("dual_c1_vld", commit1_vld, 64'h1);
        chk("dual_c0_pc", commit0_pc, 64'h8000_0000);
        chk("dual_c1_pc", commit1_pc, 64'h8000_0004);
        chk("dual_c0_old_prd", commit0_old_prd, 64'd37);
        chk("dual_c0_wb", commit0_need_to_wb, 64'h1);
        chk("dual_c0_prd", commit0_prd, 64'h1);
        chk("dual_c1_wb", commit1_need_to_wb, 64'h0);
        chk("dual_c1_skip", commit1_skip, 64'h1);
        chk("dual_head", head_ptr, 64'd2);
        chk("dual_retired", retired_cnt, 64'd2);
        chk("dual_pulse_gone", commit_vld, 64'h0);

        // head entry 2 not ready while entry 3 is: strict order blocks both
        set_entry(2, 32'h8000_0008, 7'd10, 1'b1, 1'b0, 1'b0);
        set_entry(3, 32'h8000_000c, 7'd11, 1'b1, 1'b0, 1'b1);
        #1;
        chk("order_commit_vld", commit_vld, 64'h0);
        tick();
        chk("order_head_hold", head_ptr, 64'd2);
        chk("order_c0_vld_clr", commit0_vld, 64'h0);
        chk("order_c0_pc_hold", commit0_pc, 64'h8000_0000);
        entry_ready_to_commit[2] = 1'b1;
        #1;
        chk("order_commit_vld2", commit_vld, 64'hc);
        tick();
        clr_entry(2);
        clr_entry(3);
        chk("order_head", head_ptr, 64'd4);
        chk("order_retired", retired_cnt, 64'd4);
        chk("order_c0_pc", commit0_pc, 64'h8000_0008);
        chk("order_c1_pc", commit1_pc, 64'h8000_000c);

        // flush with a ready head
        set_entry(4, 32'h8000_0010, 7'd12, 1'b0, 1'b0, 1'b1);
        flush_vld = 1'b1;
        #1;
        chk("flush_commit_vld", commit_vld, 64'h0);
        tick();
        flush_vld = 1'b0;
        clr_entry(4);
        chk("flush_head", head_ptr, 64'h0);
        chk("flush_c0_vld", commit0_vld, 64'h0);
        chk("flush_c1_vld", commit1_vld, 64'h0);
        chk("flush_retired", retired_cnt, 64'd4);

        // walk the head to 63, then retire 63 and 0 across the wrap
        for (int i = 0; i < 31; i++) begin
            set_entry(2*i, PC_RANGE'(32'h8000_0000 + 8*i), 7'd0, 1'b0, 1'b0, 1'b1);
            set_entry(2*i+1, PC_RANGE'(32'h8000_0004 + 8*i), 7'd0, 1'b0, 1'b0, 1'b1);
            tick();
            clr_entry(2*i);
            clr_entry(2*i+1);
        end
        set_entry(62, 32'h8000_00f8, 7'd0, 1'b0, 1'b0, 1'b1);
        tick();
        clr_entry(62);
        chk("walk_head", head_ptr, 64'd63);
        chk("walk_retired", retired_cnt, 64'd67);
        set_entry(63, 32'h8000_00fc, 7'd5, 1'b1, 1'b0, 1'b1);
        set_entry(0, 32'h8000_0000, 7'd6, 1'b1, 1'b0, 1'b1);
        #1;
        chk("wrap_commit_vld", commit_vld, 64'h8000_0000_0000_0001);
        tick();
        clr_entry(63);
        clr_entry(0);
        chk("wrap_head", head_ptr, 64'h41);
        chk("wrap_retired", retired_cnt, 64'd69);
        chk("wrap_c0_pc", commit0_pc, 64'h8000_00fc);
        chk("wrap_c1_pc", commit1_pc, 64'h8000_0000);

        // asynchronous reset between edges
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_head", head_ptr, 64'h0);
        chk("async_rst_retired", retired_cnt, 64'h0);
        chk("async_rst_c0_vld", commit0_vld, 64'h0);

        // watchdog: head valid but never complete
        set_entry(0, 32'h8000_0100, 7'd7, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        chk("wd_before", stall_timeout, 64'h0);
        tick();
        chk("wd_set", stall_timeout, 64'h1);
        entry_ready_to_commit[0] = 1'b1;
        tick();
        clr_entry(0);
        chk("wd_retire_c0_vld", commit0_vld, 64'h1);
        chk("wd_sticky", stall_timeout, 64'h1);
        tick();
        chk("wd_sticky2", stall_timeout, 64'h1);
        reset_n = 1'b0;
        #1;
        chk("wd_reset_clr", stall_timeout, 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
